// File: rtl/tx_retry_ctrl_pkg.sv
// Shared definitions for the TX retry controller: FSM encoding, ACK
// frame-control constants and the contention-window step helper.
package tx_retry_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_BACKOFF = 3'd1,
    ST_TX_ON        = 3'd2,
    ST_WAIT_ACK     = 3'd3,
    ST_REPORT       = 3'd4
  } tx_state_t;

  // 802.11 control frame, ACK subtype
  localparam logic [1:0] ACK_FC_TYPE    = 2'b01;
  localparam logic [3:0] ACK_FC_SUBTYPE = 4'b1101;

  // Next CW exponent after a failed attempt: +1, clamped at max_exp.
  // Since cur < max_exp <= 15 on the increment path, it never wraps.
  function automatic logic [3:0] cw_exp_next(input logic [3:0] cur,
                                             input logic [3:0] max_exp);
    if (cur >= max_exp) return max_exp;
    else                return cur + 4'd1;
  endfunction

endpackage

// File: rtl/ack_frame_match.sv
// Combinational detector for a good ACK frame addressed to this station.
module ack_frame_match
  import tx_retry_ctrl_pkg::*;
(
  input  logic        fcs_in_strobe,
  input  logic        fcs_valid,
  input  logic [1:0]  FC_type,
  input  logic [3:0]  FC_subtype,
  input  logic        addr1_valid,
  input  logic [47:0] addr1,
  input  logic [47:0] self_mac_addr,
  output logic        ack_match
);

  // Match only on a passing FCS for an ACK whose RA is our own address
  always_comb begin
    ack_match = fcs_in_strobe & fcs_valid &
                (FC_type == ACK_FC_TYPE) & (FC_subtype == ACK_FC_SUBTYPE) &
                addr1_valid & (addr1 == self_mac_addr);
  end

endmodule

// File: rtl/tx_retry_ctrl.sv
// TX retry controller: starts a transmission once backoff completes, waits
// for the ACK when one is expected, retries with a growing contention window
// up to retry_limit, and reports the packet outcome with a one-cycle strobe.
module tx_retry_ctrl
  import tx_retry_ctrl_pkg::*;
#(
  parameter int RETRY_WIDTH  = 4,
  parameter int ACK_TO_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    tsf_pulse_1M,
  input  logic                    high_tx_allowed,
  input  logic                    tx_pkt_valid,
  input  logic                    tx_pkt_need_ack,
  input  logic                    phy_tx_done,
  input  logic                    fcs_in_strobe,
  input  logic                    fcs_valid,
  input  logic [1:0]              FC_type,
  input  logic [3:0]              FC_subtype,
  input  logic                    addr1_valid,
  input  logic [47:0]             addr1,
  input  logic [47:0]             self_mac_addr,
  input  logic [ACK_TO_WIDTH-1:0] ack_timeout_time,
  input  logic [3:0]              cw_min_exp,
  input  logic [3:0]              cw_max_exp,
  input  logic [RETRY_WIDTH-1:0]  retry_limit,
  output logic                    phy_tx_start,
  output logic [3:0]              cw_exp,
  output logic [RETRY_WIDTH-1:0]  retry_count,
  output logic                    tx_pkt_done,
  output logic                    tx_pkt_success,
  output logic                    busy
);

  tx_state_t               state;
  logic                    rearm;
  logic                    need_ack;
  logic [ACK_TO_WIDTH-1:0] ack_timer;
  logic                    ack_match;

  ack_frame_match u_ack_match (
    .fcs_in_strobe (fcs_in_strobe),
    .fcs_valid     (fcs_valid),
    .FC_type       (FC_type),
    .FC_subtype    (FC_subtype),
    .addr1_valid   (addr1_valid),
    .addr1         (addr1),
    .self_mac_addr (self_mac_addr),
    .ack_match     (ack_match)
  );

  // Packet FSM with registered strobes, CW/retry bookkeeping and re-arm flag.
  // Every path back to IDLE also reloads cw_exp/retry_count so that both
  // already hold their IDLE values in the first IDLE cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      rearm          <= 1'b1;
      need_ack       <= 1'b0;
      ack_timer      <= '0;
      phy_tx_start   <= 1'b0;
      cw_exp         <= '0;
      retry_count    <= '0;
      tx_pkt_done    <= 1'b0;
      tx_pkt_success <= 1'b0;
      busy           <= 1'b0;
    end else begin
      phy_tx_start   <= 1'b0;
      tx_pkt_done    <= 1'b0;
      tx_pkt_success <= 1'b0;

      // Done clears the flag first, so the cycle after done can never restart
      if (tx_pkt_done)        rearm <= 1'b0;
      else if (!tx_pkt_valid) rearm <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          cw_exp      <= cw_min_exp;
          retry_count <= '0;
          if (tx_pkt_valid && rearm) begin
            state <= ST_WAIT_BACKOFF;
            busy  <= 1'b1;
          end
        end

        ST_WAIT_BACKOFF: begin
          if (high_tx_allowed) begin
            phy_tx_start <= 1'b1;
            need_ack     <= tx_pkt_need_ack;
            state        <= ST_TX_ON;
          end else if (!tx_pkt_valid) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            cw_exp      <= cw_min_exp;
            retry_count <= '0;
          end
        end

        ST_TX_ON: begin
          if (phy_tx_done) begin
            if (need_ack) begin
              state     <= ST_WAIT_ACK;
              ack_timer <= ack_timeout_time;
            end else begin
              state          <= ST_REPORT;
              tx_pkt_done    <= 1'b1;
              tx_pkt_success <= 1'b1;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (ack_match) begin
            state          <= ST_REPORT;
            tx_pkt_done    <= 1'b1;
            tx_pkt_success <= 1'b1;
          end else if (ack_timer == '0) begin
            if (retry_count == retry_limit) begin
              state       <= ST_REPORT;
              tx_pkt_done <= 1'b1;
            end else begin
              retry_count <= retry_count + RETRY_WIDTH'(1);
              cw_exp      <= cw_exp_next(cw_exp, cw_max_exp);
              state       <= ST_WAIT_BACKOFF;
            end
          end else if (tsf_pulse_1M) begin
            ack_timer <= ack_timer - ACK_TO_WIDTH'(1);
          end
        end

        ST_REPORT: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          cw_exp      <= cw_min_exp;
          retry_count <= '0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_retry_ctrl.sv
// Directed bench for tx_retry_ctrl: a table of per-cycle vectors for the
// basic flows plus hand-written sequences for retry, timeout and reset cases.
module tb_tx_retry_ctrl;

  localparam int RW = 4;
  localparam int AW = 9;
  localparam logic [47:0] SELF_MAC = 48'h0011_2233_4455;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tsf_pulse_1M, high_tx_allowed, tx_pkt_valid, tx_pkt_need_ack;
  logic          phy_tx_done, fcs_in_strobe, fcs_valid, addr1_valid;
  logic [1:0]    FC_type;
  logic [3:0]    FC_subtype;
  logic [47:0]   addr1, self_mac_addr;
  logic [AW-1:0] ack_timeout_time;
  logic [3:0]    cw_min_exp, cw_max_exp;
  logic [RW-1:0] retry_limit;
  logic          phy_tx_start, tx_pkt_done, tx_pkt_success, busy;
  logic [3:0]    cw_exp;
  logic [RW-1:0] retry_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_retry_ctrl #(.RETRY_WIDTH(RW), .ACK_TO_WIDTH(AW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .tsf_pulse_1M     (tsf_pulse_1M),
    .high_tx_allowed  (high_tx_allowed),
    .tx_pkt_valid     (tx_pkt_valid),
    .tx_pkt_need_ack  (tx_pkt_need_ack),
    .phy_tx_done      (phy_tx_done),
    .fcs_in_strobe    (fcs_in_strobe),
    .fcs_valid        (fcs_valid),
    .FC_type          (FC_type),
    .FC_subtype       (FC_subtype),
    .addr1_valid      (addr1_valid),
    .addr1            (addr1),
    .self_mac_addr    (self_mac_addr),
    .ack_timeout_time (ack_timeout_time),
    .cw_min_exp       (cw_min_exp),
    .cw_max_exp       (cw_max_exp),
    .retry_limit      (retry_limit),
    .phy_tx_start     (phy_tx_start),
    .cw_exp           (cw_exp),
    .retry_count      (retry_count),
    .tx_pkt_done      (tx_pkt_done),
    .tx_pkt_success   (tx_pkt_success),
    .busy             (busy)
  );

  typedef struct {
    logic        valid, need_ack, allowed, txd, tsf;
    int unsigned ack;   // 0 none, 1 good ACK, 2 wrong addr1, 3 bad FCS
    logic        e_start, e_busy, e_done, e_succ;
    logic [3:0]  e_cw, e_retry;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input int unsigned kind);
    fcs_in_strobe = (kind != 0);
    fcs_valid     = (kind != 3);
    FC_type       = 2'b01;
    FC_subtype    = 4'b1101;
    addr1_valid   = 1'b1;
    addr1         = (kind == 2) ? (SELF_MAC ^ 48'h1) : SELF_MAC;
  endtask

  task automatic clear_in();
    tsf_pulse_1M = 0; high_tx_allowed = 0; tx_pkt_valid = 0;
    tx_pkt_need_ack = 0; phy_tx_done = 0;
    set_ack(0);
  endtask

  task automatic add(input logic v, na, al, txd, tsf, input int unsigned ack,
                     input logic es, eb, ed, esu, input logic [3:0] ecw, er);
    vec_t r;
    r.valid = v; r.need_ack = na; r.allowed = al; r.txd = txd; r.tsf = tsf; r.ack = ack;
    r.e_start = es; r.e_busy = eb; r.e_done = ed; r.e_succ = esu;
    r.e_cw = ecw; r.e_retry = er;
    tbl.push_back(r);
  endtask

  task automatic wait_start(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (phy_tx_start) begin seen = 1; break; end
    end
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (tx_pkt_done) begin seen = 1; break; end
    end
  endtask

  // Idle two cycles (re-arms), start a packet, then pulse phy_tx_done once
  task automatic launch(input logic na);
    bit seen;
    clear_in();
    cyc(); cyc();
    tx_pkt_valid = 1; tx_pkt_need_ack = na; high_tx_allowed = 1;
    wait_start(10, seen);
    chk("launch_start", 32'(seen), 32'd1);
    high_tx_allowed = 0;
    phy_tx_done = 1;
    cyc();
    phy_tx_done = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen, extra, dseen;
    logic [3:0] exp_cw;

    clear_in();
    self_mac_addr = SELF_MAC;
    ack_timeout_time = 9'd3; cw_min_exp = 4'd3; cw_max_exp = 4'd6; retry_limit = 4'd3;
    rstn = 0;
    cyc(); cyc();
    chk("rst_start", 32'(phy_tx_start), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(tx_pkt_done), 0);
    chk("rst_succ",  32'(tx_pkt_success), 0);
    chk("rst_cw",    32'(cw_exp), 0);
    chk("rst_retry", 32'(retry_count), 0);
    rstn = 1;

    //  v na al txd tsf ack | start busy done succ cw retry
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // idle, cw loads min
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 3, 0);  // -> backoff
    add(1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 3, 0);  // granted -> start
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 3, 0);  // start is one cycle
    add(1, 0, 0, 1, 0, 0,   0, 1, 1, 1, 3, 0);  // no-ack: done next cycle
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // idle
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // valid held: no restart
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // valid low re-arms
    add(1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 3, 0);  // -> backoff
    add(1, 1, 1, 0, 0, 0,   1, 1, 0, 0, 3, 0);  // start, need ack
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 3, 0);  // valid ignored -> wait ack
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 3, 0);  // timer ticks
    add(0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 3, 0);  // ACK -> done/success
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // idle
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // re-arm
    add(1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 3, 0);  // -> backoff
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);  // silent abort, no done
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0);

    foreach (tbl[i]) begin
      tx_pkt_valid = tbl[i].valid; tx_pkt_need_ack = tbl[i].need_ack;
      high_tx_allowed = tbl[i].allowed; phy_tx_done = tbl[i].txd;
      tsf_pulse_1M = tbl[i].tsf; set_ack(tbl[i].ack);
      cyc();
      chk($sformatf("v%0d_start", i), 32'(phy_tx_start), 32'(tbl[i].e_start));
      chk($sformatf("v%0d_busy",  i), 32'(busy),         32'(tbl[i].e_busy));
      chk($sformatf("v%0d_done",  i), 32'(tx_pkt_done),  32'(tbl[i].e_done));
      chk($sformatf("v%0d_succ",  i), 32'(tx_pkt_success), 32'(tbl[i].e_succ));
      chk($sformatf("v%0d_cw",    i), 32'(cw_exp),       32'(tbl[i].e_cw));
      chk($sformatf("v%0d_retry", i), 32'(retry_count),  32'(tbl[i].e_retry));
    end

    // ACK 20 us after phy_tx_done with a 44 us timeout
    ack_timeout_time = 9'd44; cw_min_exp = 4'd2; cw_max_exp = 4'd7; retry_limit = 4'd3;
    launch(1);
    tsf_pulse_1M = 1;
    repeat (20) cyc();
    tsf_pulse_1M = 0;
    chk("ack20_wait_busy", 32'(busy), 1);
    chk("ack20_wait_done", 32'(tx_pkt_done), 0);
    set_ack(1);
    cyc();
    set_ack(0);
    chk("ack20_done",  32'(tx_pkt_done), 1);
    chk("ack20_succ",  32'(tx_pkt_success), 1);
    chk("ack20_retry", 32'(retry_count), 0);

    // No ACK at all: three attempts, CW 4,5,5, then failure
    clear_in(); cyc(); cyc();
    ack_timeout_time = 9'd2; cw_min_exp = 4'd4; cw_max_exp = 4'd5; retry_limit = 4'd2;
    cyc();
    tx_pkt_valid = 1; tx_pkt_need_ack = 1; high_tx_allowed = 1; tsf_pulse_1M = 1;
    for (int a = 0; a < 3; a++) begin
      exp_cw = (a == 0) ? 4'd4 : 4'd5;
      wait_start(40, seen);
      chk($sformatf("retry_start%0d", a), 32'(seen), 1);
      chk($sformatf("retry_cw%0d", a), 32'(cw_exp), 32'(exp_cw));
      chk($sformatf("retry_cnt%0d", a), 32'(retry_count), 32'(a));
      phy_tx_done = 1;
      cyc();
      phy_tx_done = 0;
    end
    extra = 0; dseen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (phy_tx_start) extra = 1;
      if (tx_pkt_done) begin dseen = 1; break; end
    end
    chk("retry_no_4th_start", 32'(extra), 0);
    chk("retry_done",  32'(dseen), 1);
    chk("retry_succ",  32'(tx_pkt_success), 0);
    chk("retry_final", 32'(retry_count), 2);
    high_tx_allowed = 0; tsf_pulse_1M = 0;
    repeat (3) cyc();
    chk("hold_valid_no_restart", 32'(busy), 0);
    tx_pkt_valid = 0;
    cyc();
    tx_pkt_valid = 1;
    cyc();
    chk("rearm_restart", 32'(busy), 1);
    tx_pkt_valid = 0;
    cyc();
    chk("rearm_abort_busy", 32'(busy), 0);
    chk("rearm_abort_done", 32'(tx_pkt_done), 0);

    // Zero timeout expires on the first WAIT_ACK cycle
    ack_timeout_time = 9'd0; retry_limit = 4'd0;
    launch(1);
    cyc();
    chk("to0_done", 32'(tx_pkt_done), 1);
    chk("to0_succ", 32'(tx_pkt_success), 0);

    // ACK in the same cycle the timer reaches zero wins
    ack_timeout_time = 9'd1; retry_limit = 4'd3;
    launch(1);
    tsf_pulse_1M = 1;
    cyc();
    tsf_pulse_1M = 0;
    set_ack(1);
    cyc();
    set_ack(0);
    chk("tie_done",  32'(tx_pkt_done), 1);
    chk("tie_succ",  32'(tx_pkt_success), 1);
    chk("tie_retry", 32'(retry_count), 0);

    // Near-miss ACKs must not count: wrong RA, then failed FCS
    ack_timeout_time = 9'd3; retry_limit = 4'd0;
    for (int k = 2; k <= 3; k++) begin
      launch(1);
      set_ack(k);
      cyc();
      set_ack(0);
      chk($sformatf("neg%0d_no_done", k), 32'(tx_pkt_done), 0);
      tsf_pulse_1M = 1;
      wait_done(20, seen);
      tsf_pulse_1M = 0;
      chk($sformatf("neg%0d_done", k), 32'(seen), 1);
      chk($sformatf("neg%0d_succ", k), 32'(tx_pkt_success), 0);
    end

    // Reset while waiting for an ACK aborts silently
    ack_timeout_time = 9'd44;
    launch(1);
    chk("rstmid_busy_before", 32'(busy), 1);
    tx_pkt_valid = 0;
    #2 rstn = 0;
    #1;
    chk("rstmid_busy",  32'(busy), 0);
    chk("rstmid_cw",    32'(cw_exp), 0);
    chk("rstmid_retry", 32'(retry_count), 0);
    #2 rstn = 1;
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (tx_pkt_done) dseen = 1;
    end
    chk("rstmid_no_done", 32'(dseen), 0);
    chk("rstmid_idle",    32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_retry_ctrl.md
TX_RETRY_CTRL -- requirements
Module: tx_retry_ctrl

Interface
REQ-001 SHALL have parameter RETRY_WIDTH, default 4: width of retry_limit and retry_count.
REQ-002 SHALL have parameter ACK_TO_WIDTH, default 9: width of ack_timeout_time, in microseconds.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 tsf_pulse_1M  in  1  one-cycle tick at 1 us.
REQ-006 high_tx_allowed  in  1  backoff complete, medium granted.
REQ-007 tx_pkt_valid  in  1  level: the queue holds a pending packet.
REQ-008 tx_pkt_need_ack  in  1  packet expects an ACK; sampled when phy_tx_start is issued.
REQ-009 phy_tx_done  in  1  strobe: PHY finished transmitting.
REQ-010 fcs_in_strobe, fcs_valid  in  1 each  receive FCS result strobe and pass flag.
REQ-011 FC_type[1:0], FC_subtype[3:0], addr1_valid, addr1[47:0], self_mac_addr[47:0]  in  received frame fields.
REQ-012 ack_timeout_time  in  ACK_TO_WIDTH  ACK wait time, in us.
REQ-013 cw_min_exp, cw_max_exp  in  4 each  contention-window exponent bounds.
REQ-014 retry_limit  in  RETRY_WIDTH  maximum number of retransmissions.
REQ-015 phy_tx_start  out  1  one-cycle strobe that starts a transmission.
REQ-016 cw_exp  out  4  current CW exponent; drives the backoff stage window input.
REQ-017 retry_count  out  RETRY_WIDTH  retransmissions so far for the current packet.
REQ-018 tx_pkt_done  out  1  one-cycle strobe: packet finished.
REQ-019 tx_pkt_success  out  1  valid with tx_pkt_done; 1 = delivered or no ACK required.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 SHALL implement five states: IDLE, WAIT_BACKOFF, TX_ON, WAIT_ACK, REPORT.
REQ-022 IDLE: cw_exp SHALL load cw_min_exp every cycle and retry_count SHALL be 0.
- Enter WAIT_BACKOFF when tx_pkt_valid=1 and the re-arm flag is set.
REQ-023 The re-arm flag SHALL clear on tx_pkt_done and set when tx_pkt_valid is sampled 0; a packet is never restarted in the cycle after done.
REQ-024 WAIT_BACKOFF:
- high_tx_allowed=1: assert phy_tx_start for exactly 1 cycle (registered, next cycle), latch tx_pkt_need_ack, go to TX_ON.
- tx_pkt_valid=0: return to IDLE silently, with no tx_pkt_done.
REQ-025 TX_ON and WAIT_ACK SHALL ignore tx_pkt_valid; a transmitted packet is committed.
REQ-026 TX_ON on phy_tx_done:
- need_ack=1: go to WAIT_ACK and load ack_timer=ack_timeout_time.
- need_ack=0: go to REPORT with success=1.
REQ-027 WAIT_ACK: ack_timer SHALL decrement on each tsf_pulse_1M while nonzero.
REQ-028 ACK match SHALL be fcs_in_strobe & fcs_valid & FC_type=2'b01 & FC_subtype=4'b1101 & addr1_valid & addr1==self_mac_addr.
- On a match: go to REPORT with success=1.
REQ-029 Timeout (ack_timer==0 and no match):
- retry_count==retry_limit: go to REPORT with success=0.
- Otherwise: retry_count+1, cw_exp=min(cw_exp+1, cw_max_exp), go to WAIT_BACKOFF.
REQ-030 An ACK match and a timeout in the same cycle SHALL resolve as success.
REQ-031 ack_timeout_time=0 SHALL time out on the first WAIT_ACK cycle.
REQ-032 cw_exp increments SHALL saturate at cw_max_exp and never wrap past 4'd15.
REQ-033 REPORT SHALL last 1 cycle: tx_pkt_done=1, tx_pkt_success as decided, then IDLE.
- retry_count SHALL hold its final value during tx_pkt_done.
REQ-034 Latency: high_tx_allowed to phy_tx_start is 1 cycle; ACK match to tx_pkt_done is 1 cycle.

Reset
REQ-035 On rstn=0, asynchronously:
- state=IDLE, re-arm flag=1, ack_timer=0.
- All outputs 0, including cw_exp=4'd0 and retry_count=0.
REQ-036 Reset mid-operation SHALL abort the packet with no tx_pkt_done.

Structure
REQ-037 A shared package SHALL hold the state encoding and the ACK frame-control constants (type 2'b01, subtype 4'b1101).
REQ-038 The ACK comparator SHALL be one sub-module, ack_frame_match.

Verification
REQ-039 need_ack=1, ACK arrives 20 us after phy_tx_done, timeout 44 -> tx_pkt_done=1, success=1, retry_count=0.
REQ-040 No ACK, retry_limit=2, cw_min_exp=4, cw_max_exp=5:
- three phy_tx_start pulses, cw_exp sequence 4,5,5;
- then tx_pkt_done with success=0, retry_count=2.
REQ-041 need_ack=0 -> tx_pkt_done with success=1 one cycle after phy_tx_done; no ACK wait.
REQ-042 ACK match in the same cycle as timer expiry -> success=1, no retry.
REQ-043 Negative match cases -> timeout behaviour, not success:
- ACK with addr1 not equal to self_mac_addr;
- ACK with fcs_valid=0.
REQ-044 tx_pkt_valid held high after done -> no restart until it drops for 1 cycle; rstn pulsed in WAIT_ACK -> IDLE, no done strobe.
